// File: rtl/sxrom_pkg.sv
// sxrom_pkg: shared constants and decode types for the MMC1-family register core.
// Contents: serial/control reset values, nametable mirroring and PRG banking mode
// enums, and a helper that maps control[3:2] onto a PRG banking mode.
package sxrom_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] SHIFT_RESET   = 5'b10000;
  localparam logic [REG_W-1:0] CONTROL_RESET = 5'b01100;

  typedef enum logic [1:0] {
    ONE_LOW    = 2'b00,
    ONE_HIGH   = 2'b01,
    VERTICAL   = 2'b10,
    HORIZONTAL = 2'b11
  } mirror_t;

  typedef enum logic [1:0] {
    SWITCH32  = 2'b00,
    FIX_FIRST = 2'b10,
    FIX_LAST  = 2'b11
  } prg_mode_t;

  // control[3:2] = 0x both select 32 KB switching
  function automatic prg_mode_t prg_mode(input logic [1:0] mode_bits);
    prg_mode_t mode;
    case (mode_bits)
      2'b10:   mode = FIX_FIRST;
      2'b11:   mode = FIX_LAST;
      default: mode = SWITCH32;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/sxrom_if.sv
// sxrom_if: CPU/PPU side bus between the enclosing mapper (master) and the register
// core (slave).
// master drives: cpu_addr, cpu_rw, cpu_data_in, ppu_addr, chr_ram
// slave drives : prg_bank, chr_bank, wram_bank, wram_en, ciram_a10
interface sxrom_if #(
  parameter int unsigned PRG_BITS  = 5,
  parameter int unsigned WRAM_BITS = 2
);

  localparam int unsigned WRAM_W = (WRAM_BITS > 0) ? WRAM_BITS : 1;

  logic [15:0]         cpu_addr;
  logic                cpu_rw;
  logic [7:0]          cpu_data_in;
  logic [13:0]         ppu_addr;
  logic                chr_ram;
  logic [PRG_BITS-1:0] prg_bank;
  logic [4:0]          chr_bank;
  logic [WRAM_W-1:0]   wram_bank;
  logic                wram_en;
  logic                ciram_a10;

  modport master (
    output cpu_addr, cpu_rw, cpu_data_in, ppu_addr, chr_ram,
    input  prg_bank, chr_bank, wram_bank, wram_en, ciram_a10
  );

  modport slave (
    input  cpu_addr, cpu_rw, cpu_data_in, ppu_addr, chr_ram,
    output prg_bank, chr_bank, wram_bank, wram_en, ciram_a10
  );

endinterface

// File: rtl/sxrom_serial.sv
// sxrom_serial: 5-bit LSB-first serial port of the MMC1 register core.
// Ports: m2 (state changes on falling edge), reset (async, active-high),
//        port_wr (CPU write to $8000-$FFFF this cycle), data7/data0 (write data bits),
//        addr_sel (cpu_addr[14:13]); outputs load (5th bit strobe), ctl_reset
//        (data bit 7 strobe), sel (target register), value (assembled 5-bit word).
// The strobes are combinational for the current cycle and are consumed by the parent
// on the same falling edge.
// Build option: SXROM_WRITE_FILTER_EN enables the consecutive-cycle write filter
// (last_wr); when undefined every port write is accepted.
module sxrom_serial
  import sxrom_pkg::*;
(
  input  logic             m2,
  input  logic             reset,
  input  logic             port_wr,
  input  logic             data7,
  input  logic             data0,
  input  logic [1:0]       addr_sel,
  output logic             load,
  output logic             ctl_reset,
  output logic [1:0]       sel,
  output logic [REG_W-1:0] value
);

  logic [REG_W-1:0] shift_q, shift_d;
  logic             accept_c;

`ifdef SXROM_WRITE_FILTER_EN
  logic last_wr_q, last_wr_d;

  // Second write of a back-to-back pair (RMW double write) is dropped
  always_comb begin
    last_wr_d = port_wr;
    accept_c  = ~last_wr_q;
  end

  always_ff @(negedge m2 or posedge reset) begin
    if (reset) last_wr_q <= 1'b0;
    else       last_wr_q <= last_wr_d;
  end
`else
  always_comb accept_c = 1'b1;
`endif

  // Marker bit in shift_q[0] flags that four bits are already held
  always_comb begin
    shift_d   = shift_q;
    load      = 1'b0;
    ctl_reset = 1'b0;
    sel       = addr_sel;
    value     = {data0, shift_q[REG_W-1:1]};
    if (port_wr) begin
      if (data7) begin
        shift_d   = SHIFT_RESET;
        ctl_reset = 1'b1;
      end else if (accept_c) begin
        if (shift_q[0]) begin
          load    = 1'b1;
          shift_d = SHIFT_RESET;
        end else begin
          shift_d = value;
        end
      end
    end
  end

  always_ff @(negedge m2 or posedge reset) begin
    if (reset) shift_q <= SHIFT_RESET;
    else       shift_q <= shift_d;
  end

endmodule

// File: rtl/sxrom_ctrl.sv
// sxrom_ctrl: MMC1-family (SNROM/SOROM/SUROM/SXROM) register core.
// Ports: m2 (CPU M2, state changes on falling edge), reset (async, active-high),
//        bus (sxrom_if.slave: CPU/PPU addresses, write data, chr_ram in;
//        prg_bank, chr_bank, wram_bank, wram_en, ciram_a10 out).
// Parameters: PRG_BITS (4 plain, 5 with outer 256 KB select), WRAM_BITS (0/1/2).
// Outputs are combinational decode of the registers and the live addresses.
// Build option: SXROM_WRITE_FILTER_EN (handled inside sxrom_serial).
module sxrom_ctrl
  import sxrom_pkg::*;
#(
  parameter int unsigned PRG_BITS  = 5,
  parameter int unsigned WRAM_BITS = 2
) (
  input logic   m2,
  input logic   reset,
  sxrom_if.slave bus
);

  logic [REG_W-1:0] control_q, control_d;
  logic [REG_W-1:0] chr0_q, chr0_d;
  logic [REG_W-1:0] chr1_q, chr1_d;
  logic [REG_W-1:0] prg_q, prg_d;

  logic             port_wr_c;
  logic             load_c;
  logic             ctl_reset_c;
  logic [1:0]       sel_c;
  logic [REG_W-1:0] value_c;

  assign port_wr_c = bus.cpu_addr[15] & ~bus.cpu_rw;

  sxrom_serial u_serial (
    .m2        (m2),
    .reset     (reset),
    .port_wr   (port_wr_c),
    .data7     (bus.cpu_data_in[7]),
    .data0     (bus.cpu_data_in[0]),
    .addr_sel  (bus.cpu_addr[14:13]),
    .load      (load_c),
    .ctl_reset (ctl_reset_c),
    .sel       (sel_c),
    .value     (value_c)
  );

  // Target register update: bit-7 reset forces 16 KB fix-last mode
  always_comb begin
    control_d = control_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    if (ctl_reset_c) begin
      control_d = control_q | CONTROL_RESET;
    end else if (load_c) begin
      case (sel_c)
        2'd0:    control_d = value_c;
        2'd1:    chr0_d    = value_c;
        2'd2:    chr1_d    = value_c;
        default: prg_d     = value_c;
      endcase
    end
  end

  always_ff @(negedge m2 or posedge reset) begin
    if (reset) begin
      control_q <= CONTROL_RESET;
      chr0_q    <= '0;
      chr1_q    <= '0;
      prg_q     <= '0;
    end else begin
      control_q <= control_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
    end
  end

  logic [REG_W-1:0] cur_c;
  logic [REG_W-1:0] chr_c;
  logic [3:0]       inner_c;
  logic             outer_c;
  logic             a10_c;

  // Bank decode from registers and current CPU/PPU addresses
  always_comb begin
    cur_c   = (control_q[4] && bus.ppu_addr[12]) ? chr1_q : chr0_q;
    chr_c   = cur_c;
    inner_c = {prg_q[3:1], bus.cpu_addr[14]};
    outer_c = bus.chr_ram & cur_c[4];
    a10_c   = 1'b0;

    if (bus.chr_ram)        chr_c = {4'b0000, bus.ppu_addr[12]};
    else if (!control_q[4]) chr_c = {chr0_q[4:1], bus.ppu_addr[12]};

    case (prg_mode(control_q[3:2]))
      FIX_FIRST: inner_c = bus.cpu_addr[14] ? prg_q[3:0] : 4'h0;
      FIX_LAST:  inner_c = bus.cpu_addr[14] ? 4'hF : prg_q[3:0];
      default:   inner_c = {prg_q[3:1], bus.cpu_addr[14]};
    endcase

    case (mirror_t'(control_q[1:0]))
      ONE_LOW:    a10_c = 1'b0;
      ONE_HIGH:   a10_c = 1'b1;
      VERTICAL:   a10_c = bus.ppu_addr[10];
      HORIZONTAL: a10_c = bus.ppu_addr[11];
      default:    a10_c = 1'b0;
    endcase
  end

  assign bus.chr_bank  = chr_c;
  assign bus.wram_en   = ~prg_q[4];
  assign bus.ciram_a10 = a10_c;

  // Outer select bit also lifts the fixed 0/F banks
  if (PRG_BITS > 4) begin : g_prg_outer
    assign bus.prg_bank = PRG_BITS'({outer_c, inner_c});
  end else begin : g_prg_plain
    assign bus.prg_bank = PRG_BITS'(inner_c);
  end

  if (WRAM_BITS == 0) begin : g_wram_none
    assign bus.wram_bank = '0;
  end else begin : g_wram_sel
    assign bus.wram_bank = bus.chr_ram ? cur_c[3 -: WRAM_BITS] : '0;
  end

  logic unused_c;
  assign unused_c = ^{bus.cpu_data_in[6:1], bus.cpu_addr[12:0],
                      bus.ppu_addr[13], bus.ppu_addr[9:0], outer_c};

endmodule

// File: tb/tb_sxrom_ctrl.sv
// tb_sxrom_ctrl: directed scenarios plus randomized bus traffic for sxrom_ctrl,
// checked against a bit-counting behavioural model of the MMC1 register file.
module tb_sxrom_ctrl;

  localparam int unsigned PRG_BITS  = 5;
  localparam int unsigned WRAM_BITS = 2;
`ifdef SXROM_WRITE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic m2 = 1'b0;
  logic reset;

  sxrom_if #(.PRG_BITS(PRG_BITS), .WRAM_BITS(WRAM_BITS)) bus ();

  sxrom_ctrl #(.PRG_BITS(PRG_BITS), .WRAM_BITS(WRAM_BITS)) dut (
    .m2    (m2),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 m2 = ~m2;

  int checks = 0;
  int errors = 0;

  // Model state: registers as plain integers, serial port as bit count + accumulator
  int m_ctrl, m_chr0, m_chr1, m_prg, m_cnt, m_acc;
  bit m_last;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
    m_cnt = 0; m_acc = 0; m_last = 1'b0;
  endfunction

  function automatic void model_step(input logic [15:0] a, input logic rw, input logic [7:0] d);
    bit port;
    port = a[15] && !rw;
    if (port) begin
      if (d[7]) begin
        m_cnt = 0; m_acc = 0; m_ctrl = m_ctrl | 12;
      end else if (!(FILTER && m_last)) begin
        m_acc = m_acc | (int'(d[0]) << m_cnt);
        m_cnt++;
        if (m_cnt == 5) begin
          case (int'(a[14:13]))
            0: m_ctrl = m_acc;
            1: m_chr0 = m_acc;
            2: m_chr1 = m_acc;
            default: m_prg = m_acc;
          endcase
          m_cnt = 0; m_acc = 0;
        end
      end
    end
    m_last = port;
  endfunction

  always @(negedge m2) begin
    if (reset === 1'b0) model_step(bus.cpu_addr, bus.cpu_rw, bus.cpu_data_in);
  end

  task automatic check_outputs(input string tag);
    int a14, p10, p11, p12, cr, cur, mode, inner, e_prg, e_chr, e_wram, e_a10;
    a14 = int'(bus.cpu_addr[14]);
    p10 = int'(bus.ppu_addr[10]);
    p11 = int'(bus.ppu_addr[11]);
    p12 = int'(bus.ppu_addr[12]);
    cr  = int'(bus.chr_ram);
    cur = (((m_ctrl >> 4) & 1) == 1 && p12 == 1) ? m_chr1 : m_chr0;
    if (cr == 1)                    e_chr = p12;
    else if (((m_ctrl >> 4) & 1) == 0) e_chr = (m_chr0 & 30) + p12;
    else                            e_chr = cur;
    mode = (m_ctrl >> 2) & 3;
    if (mode < 2)       inner = (m_prg & 14) + a14;
    else if (mode == 2) inner = (a14 == 1) ? (m_prg & 15) : 0;
    else                inner = (a14 == 1) ? 15 : (m_prg & 15);
    e_prg  = inner + ((cr == 1) ? (cur & 16) : 0);
    e_wram = (cr == 1) ? ((cur >> 2) & 3) : 0;
    case (m_ctrl & 3)
      0: e_a10 = 0;
      1: e_a10 = 1;
      2: e_a10 = p10;
      default: e_a10 = p11;
    endcase
    check_eq({tag, ".prg"},  int'(bus.prg_bank),  e_prg);
    check_eq({tag, ".chr"},  int'(bus.chr_bank),  e_chr);
    check_eq({tag, ".wram"}, int'(bus.wram_bank), e_wram);
    check_eq({tag, ".wen"},  int'(bus.wram_en),   ((m_prg >> 4) & 1) ^ 1);
    check_eq({tag, ".a10"},  int'(bus.ciram_a10), e_a10);
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(posedge m2); #1;
    bus.cpu_addr = a; bus.cpu_rw = rw; bus.cpu_data_in = d;
    @(negedge m2); #1;
    bus.cpu_rw = 1'b1;
  endtask

  task automatic write_spaced(input logic [15:0] a, input logic [7:0] d);
    bus_cycle(a, 1'b0, d);
    bus_cycle(a, 1'b1, 8'h00);
  endtask

  task automatic load_reg(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) write_spaced(a, {7'b0, v[i]});
  endtask

  task automatic peek(input logic [15:0] a, input logic [13:0] p);
    bus.cpu_addr = a; bus.ppu_addr = p; #1;
  endtask

  // One-cycle reset pulse; outputs must show reset values while reset is held
  task automatic reset_pulse(input string tag);
    @(posedge m2); #1;
    reset = 1'b1; model_reset();
    peek(16'hC000, 14'h0000);
    check_eq({tag, ".wen"}, int'(bus.wram_en), 1);
    check_outputs(tag);
    @(posedge m2); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic        r_rw;

  initial begin
    reset = 1'b1;
    bus.cpu_addr = 16'hC000; bus.cpu_rw = 1'b1; bus.cpu_data_in = 8'h00;
    bus.ppu_addr = 14'h0000; bus.chr_ram = 1'b0;
    model_reset();
    repeat (2) @(negedge m2);
    #1 reset = 1'b0;

    // Reset state
    peek(16'hC000, 14'h0000);
    check_eq("rst.prg", int'(bus.prg_bank), 'h0F);
    check_eq("rst.a10", int'(bus.ciram_a10), 0);
    check_eq("rst.wen", int'(bus.wram_en), 1);
    check_eq("rst.chr", int'(bus.chr_bank), 0);

    // prg = 6 via bits 0,1,1,0,0
    load_reg(16'hE000, 5'b00110);
    peek(16'h8000, 14'h0000);
    check_eq("prg6.lo", int'(bus.prg_bank), 6);
    peek(16'hC000, 14'h0000);
    check_eq("prg6.hi", int'(bus.prg_bank), 'h0F);
    check_outputs("prg6");

    // CHR RAM board: chr0 bits become outer PRG / WRAM bank
    load_reg(16'hA000, 5'b11100);
    bus.chr_ram = 1'b1;
    peek(16'h8000, 14'h0000);
    check_eq("chrram.prg", int'(bus.prg_bank), 'h16);
    check_eq("chrram.wram", int'(bus.wram_bank), 3);
    check_outputs("chrram");
    bus.chr_ram = 1'b0;

    // Bit-7 reset in the middle of a sequence
    load_reg(16'h8000, 5'b00000);
    peek(16'hC000, 14'h0000);
    check_eq("mode0.hi", int'(bus.prg_bank), 7);
    write_spaced(16'hE000, 8'h01);
    write_spaced(16'hE000, 8'h00);
    write_spaced(16'hE000, 8'h01);
    write_spaced(16'h8000, 8'h80);
    peek(16'hC000, 14'h0000);
    check_eq("b7.hi", int'(bus.prg_bank), 'h0F);
    load_reg(16'hE000, 5'b01001);
    peek(16'h8000, 14'h0000);
    check_eq("b7.reload", int'(bus.prg_bank), 9);
    check_outputs("b7");

    // Adjacent-cycle writes: second one dropped only when the filter is built in
    bus_cycle(16'hE000, 1'b0, 8'h01);
    bus_cycle(16'hE000, 1'b0, 8'h00);
    bus_cycle(16'hE000, 1'b1, 8'h00);
    write_spaced(16'hE000, 8'h01);
    write_spaced(16'hE000, 8'h01);
    write_spaced(16'hE000, 8'h00);
    write_spaced(16'hE000, 8'h00);
    peek(16'h8000, 14'h0000);
    check_eq("filter.prg", int'(bus.prg_bank), FILTER ? 7 : 13);
    check_outputs("filter");
    write_spaced(16'h8000, 8'h80);

    // Mirroring and 4 KB CHR mode
    load_reg(16'h8000, 5'b11111);
    load_reg(16'hA000, 5'h0A);
    load_reg(16'hC000, 5'h15);
    peek(16'h8000, 14'h1800);
    check_eq("chr4k.hi", int'(bus.chr_bank), 'h15);
    check_eq("mirror.h", int'(bus.ciram_a10), 1);
    peek(16'h8000, 14'h0400);
    check_eq("chr4k.lo", int'(bus.chr_bank), 'h0A);
    check_eq("mirror.h0", int'(bus.ciram_a10), 0);
    check_outputs("chr4k");

    // Reset after 4 of 5 bits discards the partial word
    write_spaced(16'hE000, 8'h01);
    write_spaced(16'hE000, 8'h00);
    write_spaced(16'hE000, 8'h01);
    write_spaced(16'hE000, 8'h00);
    reset_pulse("midrst");
    check_eq("midrst.prg", int'(bus.prg_bank), 'h0F);
    check_eq("midrst.chr", int'(bus.chr_bank), 0);
    load_reg(16'hE000, 5'b10101);
    peek(16'h8000, 14'h0000);
    check_eq("midrst.reload", int'(bus.prg_bank), 5);
    check_eq("midrst.wen", int'(bus.wram_en), 0);
    check_outputs("midrst");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r_addr = 16'($urandom);
      r_addr[15] = ($urandom_range(0, 3) != 0);
      r_rw = ($urandom_range(0, 3) == 0);
      r_data = 8'($urandom);
      r_data[7] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) bus.chr_ram = ~bus.chr_ram;
      if ($urandom_range(0, 99) == 0) reset_pulse("rndrst");
      bus_cycle(r_addr, r_rw, r_data);
      peek(16'($urandom), 14'($urandom));
      check_outputs("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
